dct_transpose_buffer: RTL and testbench
=======================================

DCT_TRANSPOSE_BUFFER -- requirements
Module: dct_transpose_buffer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the signed sample width.
REQ-002 The module SHALL have parameter DIM, default 8, giving the block dimension (rows, columns, samples per beat).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-005 The module SHALL have port flush, input, 1, a synchronous discard of all buffered data.
REQ-006 The module SHALL have port in_valid, input, 1, meaning a row beat is offered.
REQ-007 The module SHALL have port in_ready, output, 1, meaning a row beat can be accepted.
REQ-008 The module SHALL have port in_row, input, DIM x WIDTH signed, the first-stage clipped row (element j = column j).
REQ-009 The module SHALL have port out_valid, output, 1, meaning a column beat is offered.
REQ-010 The module SHALL have port out_ready, input, 1, meaning downstream accepts the column beat.
REQ-011 The module SHALL have port out_col, output, DIM x WIDTH signed, the transposed column (element j = row j).
REQ-012 The module SHALL have port out_col_idx, output, clog2(DIM), the index of the column being offered.
REQ-013 The module SHALL have port out_last, output, 1, high with the final column (idx DIM-1) of a block.

Function
REQ-014 The module SHALL store data in two DIM x DIM banks (ping-pong), each with a full flag.
REQ-015 A write transfer SHALL occur when in_valid and in_ready are both high on a clock edge.
REQ-016 in_ready SHALL be high exactly when the current write bank's full flag is clear.
REQ-017 A write transfer SHALL store in_row into row wr_row of the write bank, then increment wr_row.
REQ-018 On the transfer with wr_row = DIM-1, the module SHALL set that bank's full flag, toggle the write bank and set wr_row to 0.
REQ-019 out_valid SHALL be high exactly when the current read bank's full flag is set.
REQ-020 While out_valid is high, out_col[j] SHALL equal element [row j][column rd_col] of the read bank; while out_valid is low, out_col SHALL be all zero.
REQ-021 out_col_idx SHALL equal rd_col, and out_last SHALL be (out_valid and rd_col = DIM-1).
REQ-022 A read transfer SHALL occur when out_valid and out_ready are both high, and SHALL increment rd_col.
REQ-023 On the read transfer with rd_col = DIM-1, the module SHALL clear that bank's full flag, toggle the read bank and set rd_col to 0.
REQ-024 out_valid SHALL rise on the edge that accepts the DIM-th row of a block (latency 1 cycle from final row to first column); the block SHALL be held stable while out_ready is low.
REQ-025 Completing a fill of one bank and a drain of the other on the same edge SHALL both take effect on that edge.
REQ-026 in_ready SHALL be low only when both banks are full; the module SHALL then accept no further writes until a drain completes.
REQ-027 in_ready SHALL rise on the edge completing that drain (no combinational path from out_ready to in_ready).
REQ-028 Data SHALL pass without modification and with no width change; blocks SHALL be emitted in arrival order.
REQ-029 When flush is high on an edge, the module SHALL clear both full flags, both bank pointers, wr_row and rd_col, and SHALL ignore any same-edge transfers.
REQ-030 Storage contents need not be reset or flushed.

Reset
REQ-031 While rst is high, the module SHALL hold both full flags 0, write and read bank pointers 0, wr_row 0 and rd_col 0.
REQ-032 While rst is high, outputs SHALL be in_ready=1, out_valid=0, out_col=0, out_col_idx=0 and out_last=0.
REQ-033 Reset asserted mid-block SHALL discard the partial block, and the first row after release SHALL be written as row 0 of bank 0.

Verification
REQ-034 Test 1 SHALL write 8 rows with row r element c = 10r+c, out_ready=1; required response: columns 0..7 out on consecutive cycles starting 1 cycle after row 7, col c element r = 10r+c, out_last only on col 7.
REQ-035 Test 2 SHALL stream 3 blocks back-to-back with out_ready=1; required response: in_ready stays 1, and 24 columns are emitted in order with no gap after the first.
REQ-036 Test 3 SHALL hold out_ready=0 and offer 20 rows; required response: in_ready drops after row 16; raising out_ready then gives in_ready=1 one cycle after the 8th column; out_col is stable while stalled.
REQ-037 Test 4 SHALL drain bank 0's last column on the same edge as bank 1's 8th row; required response: next cycle out_valid=1, out_col_idx=0, from bank 1.
REQ-038 Test 5 SHALL assert rst asynchronously mid-cycle after 5 rows, then send 8 new rows; required response: outputs reset immediately, and only the new block is emitted.
REQ-039 Test 6 SHALL assert flush with in_valid=1 during a partial block and a full bank; required response: next cycle out_valid=0, in_ready=1, and the flushed-edge row is not stored.
REQ-040 Test 7 SHALL write rows of value -32768 and 32767; required response: columns reproduce them bit-exact, with sign preserved.

Source files
------------

// File: rtl/dct_transpose_buffer.sv
// dct_transpose_buffer
// Ping-pong transpose buffer between the row and column passes of a 2-D DCT.
// Rows of a DIM x DIM block are written one beat at a time into one bank while
// the other bank is read out column by column. Each bank has a full flag. A
// bank is filled completely before it is read, and read completely before it
// is refilled.
module dct_transpose_buffer #(
    parameter int WIDTH = 16,
    parameter int DIM   = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [DIM-1:0][WIDTH-1:0]    in_row,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [DIM-1:0][WIDTH-1:0]    out_col,
    output logic        [$clog2(DIM)-1:0]       out_col_idx,
    output logic                                out_last
);

    localparam int            IW   = $clog2(DIM);
    localparam logic [IW-1:0] LAST = IW'(DIM - 1);

    // Two banks, indexed [bank][row][column].
    logic signed [WIDTH-1:0] mem [2][DIM][DIM];

    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [IW-1:0] wr_row;
    logic [IW-1:0] rd_col;

    logic wr_fire;
    logic rd_fire;

    // Handshake status comes from registered flags only, so out_ready never
    // reaches in_ready combinationally. A flush cancels both transfers.
    assign in_ready    = ~full[wr_bank];
    assign out_valid   = full[rd_bank];
    assign out_col_idx = rd_col;
    assign out_last    = out_valid && (rd_col == LAST);
    assign wr_fire     = in_valid && in_ready && !flush;
    assign rd_fire     = out_valid && out_ready && !flush;

    // Bank pointers, row/column counters and full flags.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
        end else if (flush) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
        end else begin
            // A fill can only target an empty bank and a drain only a full one,
            // so when both complete on one edge they touch different flags.
            if (wr_fire) begin
                if (wr_row == LAST) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_row        <= '0;
                end else begin
                    wr_row <= wr_row + IW'(1);
                end
            end
            if (rd_fire) begin
                if (rd_col == LAST) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    rd_col        <= '0;
                end else begin
                    rd_col <= rd_col + IW'(1);
                end
            end
        end
    end

    // Store the accepted row into the current write bank.
    // NOTE: the storage array has no reset. Its contents are never observable
    // until the bank's full flag is set, and that only happens after a complete
    // rewrite of the bank.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int j = 0; j < DIM; j++) begin
                mem[wr_bank][wr_row][j] <= in_row[j];
            end
        end
    end

    // Gather column rd_col of the read bank. The result is zero when the read
    // bank is not full.
    // NOTE: out_col receives a default before any conditional assignment, so
    // no latch is inferred.
    always_comb begin
        out_col = '0;
        if (out_valid) begin
            for (int j = 0; j < DIM; j++) begin
                out_col[j] = mem[rd_bank][j][rd_col];
            end
        end
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// tb_dct_transpose_buffer
// Directed bench for the DCT transpose buffer. Inputs are driven 1 time unit
// after each rising edge. Outputs are checked at that same point, which lies
// well away from the next edge.
module tb_dct_transpose_buffer;

    localparam int WIDTH = 16;
    localparam int DIM   = 8;

    typedef logic signed [DIM-1:0][WIDTH-1:0] vec_t;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    vec_t                   in_row;
    logic                   out_valid;
    logic                   out_ready;
    vec_t                   out_col;
    logic [$clog2(DIM)-1:0] out_col_idx;
    logic                   out_last;

    int n_tests = 0;
    int n_fail  = 0;

    dct_transpose_buffer #(.WIDTH(WIDTH), .DIM(DIM)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_col     (out_col),
        .out_col_idx (out_col_idx),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Build row r of a block: element c = base + 10r + c.
    function automatic vec_t gen_row(input int base, input int r);
        vec_t v;
        for (int c = 0; c < DIM; c++) v[c] = WIDTH'(base + 10 * r + c);
        return v;
    endfunction

    // Expected column c of that block: element r = base + 10r + c.
    function automatic vec_t exp_col(input int base, input int c);
        vec_t v;
        for (int r = 0; r < DIM; r++) v[r] = WIDTH'(base + 10 * r + c);
        return v;
    endfunction

    // Extreme-value pattern: element (r,c) is 32767 when r+c is odd, else -32768.
    function automatic logic signed [WIDTH-1:0] ext_val(input int r, input int c);
        return ((r + c) % 2 == 1) ? 16'sh7FFF : 16'sh8000;
    endfunction

    task automatic fill_block(input int base, input int rows);
        for (int r = 0; r < rows; r++) begin
            in_valid = 1'b1;
            in_row   = gen_row(base, r);
            step();
        end
        in_valid = 1'b0;
    endtask

    // Expect DIM consecutive column beats of a block. out_ready must be high.
    task automatic drain_block(input string tag, input int base);
        for (int c = 0; c < DIM; c++) begin
            check($sformatf("%s_valid%0d", tag, c), out_valid, 1);
            check($sformatf("%s_idx%0d", tag, c), out_col_idx, c);
            check($sformatf("%s_col%0d", tag, c), out_col, exp_col(base, c));
            check($sformatf("%s_last%0d", tag, c), out_last, (c == DIM - 1));
            step();
        end
    endtask

    initial begin
        int   k;
        int   n;
        vec_t v;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_col", out_col, 0);
        check("rst_idx", out_col_idx, 0);
        check("rst_last", out_last, 0);
        rst = 1'b0;
        step();

        // Test 1: a single block. The first column appears one cycle after row 7.
        out_ready = 1'b1;
        fill_block(0, 7);
        check("t1_pre_valid", out_valid, 0);
        in_valid = 1'b1;
        in_row   = gen_row(0, 7);
        step();
        in_valid = 1'b0;
        drain_block("t1", 0);
        check("t1_post_valid", out_valid, 0);

        // Test 2: three blocks back to back. No stall and no output gaps.
        k = 0;
        for (int t = 0; t < 40; t++) begin
            in_valid = (t < 3 * DIM);
            in_row   = gen_row(100 * (t / DIM), t % DIM);
            if (t < 3 * DIM) check($sformatf("t2_in_ready%0d", t), in_ready, 1);
            if (out_valid && k < 3 * DIM) begin
                check($sformatf("t2_cycle%0d", k), t, DIM + k);
                check($sformatf("t2_col%0d", k), out_col, exp_col(100 * (k / DIM), k % DIM));
                k++;
            end
            step();
        end
        in_valid = 1'b0;
        check("t2_count", k, 3 * DIM);
        check("t2_idle", out_valid, 0);

        // Test 3: stalled output. Two blocks fill, then the input back-pressures.
        out_ready = 1'b0;
        n = 0;
        for (int t = 0; t < 20; t++) begin
            in_valid = 1'b1;
            in_row   = gen_row(300 + 100 * (n / DIM), n % DIM);
            check($sformatf("t3_in_ready%0d", t), in_ready, (t < 2 * DIM));
            if (t >= DIM) begin
                check($sformatf("t3_stall_valid%0d", t), out_valid, 1);
                check($sformatf("t3_stall_col%0d", t), out_col, exp_col(300, 0));
            end
            if (in_ready) n++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < DIM; c++) begin
            check($sformatf("t3_drain_ready%0d", c), in_ready, 0);
            check($sformatf("t3_drain_col%0d", c), out_col, exp_col(300, c));
            step();
        end
        check("t3_ready_back", in_ready, 1);
        drain_block("t3b", 400);
        check("t3_idle", out_valid, 0);

        // Test 4: bank 0 drains its last column on the edge that fills bank 1.
        out_ready = 1'b0;
        fill_block(500, DIM);
        fill_block(600, DIM - 1);
        out_ready = 1'b1;
        for (int c = 0; c < DIM - 1; c++) step();
        in_valid = 1'b1;
        in_row   = gen_row(600, DIM - 1);
        check("t4_pre_last", out_last, 1);
        check("t4_pre_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("t4_valid", out_valid, 1);
        check("t4_idx", out_col_idx, 0);
        check("t4_col", out_col, exp_col(600, 0));
        check("t4_in_ready", in_ready, 1);
        drain_block("t4b", 600);
        check("t4_idle", out_valid, 0);

        // Test 5: asynchronous reset with one full bank and a partial block.
        out_ready = 1'b0;
        fill_block(700, DIM);
        fill_block(800, 5);
        #3 rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready, 1);
        check("t5_rst_col", out_col, 0);
        check("t5_rst_last", out_last, 0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        fill_block(900, DIM);
        drain_block("t5", 900);
        check("t5_idle", out_valid, 0);

        // Test 6: flush with one full bank and a partial block. The row offered
        // on the flush edge is dropped.
        out_ready = 1'b0;
        fill_block(1000, DIM);
        fill_block(1100, 3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_row   = gen_row(2000, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t6_valid", out_valid, 0);
        check("t6_ready", in_ready, 1);
        check("t6_col", out_col, 0);
        out_ready = 1'b1;
        fill_block(1200, DIM);
        drain_block("t6", 1200);
        check("t6_idle", out_valid, 0);

        // Test 7: full-scale signed values pass through bit-exact.
        out_ready = 1'b1;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) v[c] = ext_val(r, c);
            in_valid = 1'b1;
            in_row   = v;
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < DIM; c++) begin
            for (int r = 0; r < DIM; r++) v[r] = ext_val(r, c);
            check($sformatf("t7_col%0d", c), out_col, v);
            check($sformatf("t7_sign%0d", c), out_col[0][WIDTH-1], (c % 2 == 0));
            step();
        end
        check("t7_idle", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
